// File: rtl/fp16_mul_round.sv
// fp16_mul_round
//   Back end of the binary16 multiplier. Takes the raw 11x11 significand product
//   together with both original operands, classifies the operands, normalises the
//   product, rounds to nearest-even and packs a binary16 result with exception flags.
//   Two register stages with a valid/ready handshake on both sides; in_ready is
//   combinational (no skid buffer), so a full pipeline stalls the producer directly.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset (clears valids and output registers)
//   in_valid   input beat valid
//   in_ready   stage can accept a beat this cycle
//   in_a/in_b  binary16 operands
//   in_prod    {1,a_frac}*{1,b_frac} from the significand multiplier, same cycle
//   out_valid  result valid
//   out_ready  consumer accepts result
//   out_z      binary16 product
//   out_flags  {invalid, overflow, underflow, inexact}
module fp16_mul_round #(
  parameter int          EXP_W  = 5,
  parameter int          FRAC_W = 10,
  parameter int          BIAS   = 15,
  parameter logic [15:0] QNAN   = 16'h7E00,
  localparam int         W      = 1 + EXP_W + FRAC_W,
  localparam int         SIG_W  = FRAC_W + 1,
  localparam int         PROD_W = 2 * SIG_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W-1:0]      in_a,
  input  logic [W-1:0]      in_b,
  input  logic [PROD_W-1:0] in_prod,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W-1:0]      out_z,
  output logic [3:0]        out_flags
);

  // Exponent is carried two bits wider than the field so that both the
  // underflow (negative) and overflow (>= all-ones) ranges are representable.
  localparam int EW = EXP_W + 2;
  localparam logic signed [EW-1:0] E_ONE  = EW'(1);
  localparam logic signed [EW-1:0] E_MAX  = EW'((2 ** EXP_W) - 1);
  localparam logic signed [EW-1:0] E_BIAS = EW'(BIAS);

  // Round-nearest-even on the normalised significand. A carry out of the
  // significand renormalises to 1.0 and bumps the exponent. Returns
  // {exponent, stored fraction}.
  function automatic logic [EW+FRAC_W-1:0] round_rne(
    input logic signed [EW-1:0] e,
    input logic [SIG_W-1:0]     sig,
    input logic                 g,
    input logic                 st
  );
    logic [SIG_W:0]         sum;
    logic signed [EW-1:0]   e_r;
    logic [FRAC_W-1:0]      f_r;
    sum = {1'b0, sig} + {{SIG_W{1'b0}}, g & (st | sig[0])};
    if (sum[SIG_W]) begin
      e_r = e + E_ONE;
      f_r = '0;
    end else begin
      e_r = e;
      f_r = sum[FRAC_W-1:0];
    end
    return {e_r, f_r};
  endfunction

  logic                 vld_p1_q, vld_p2_q;
  logic                 adv1, adv2;

  logic                 nan_p1_d, snan_p1_d, inf_p1_d, zero_p1_d, sign_p1_d;
  logic signed [EW-1:0] e_p1_d;
  logic [SIG_W-1:0]     sig_p1_d;
  logic                 g_p1_d, st_p1_d;

  logic                 nan_p1_q, snan_p1_q, inf_p1_q, zero_p1_q, sign_p1_q;
  logic signed [EW-1:0] e_p1_q;
  logic [SIG_W-1:0]     sig_p1_q;
  logic                 g_p1_q, st_p1_q;

  logic signed [EW-1:0] e_r;
  logic [FRAC_W-1:0]    frac_r;
  logic [W-1:0]         z_p2_d, z_p2_q;
  logic [3:0]           flags_p2_d, flags_p2_q;

  logic [EXP_W-1:0]     ea, eb;
  logic [FRAC_W-1:0]    fa, fb;
  logic                 a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic signed [EW-1:0] e_sum;

  assign adv2      = !vld_p2_q || out_ready;
  assign adv1      = !vld_p1_q || adv2;
  assign in_ready  = adv1;
  assign out_valid = vld_p2_q;
  assign out_z     = z_p2_q;
  assign out_flags = flags_p2_q;

  assign ea = in_a[W-2 -: EXP_W];
  assign eb = in_b[W-2 -: EXP_W];
  assign fa = in_a[FRAC_W-1:0];
  assign fb = in_b[FRAC_W-1:0];

  // Exponent 0 is zero regardless of fraction: denormals are flushed on input.
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (&ea) && (fa == '0);
  assign b_inf  = (&eb) && (fb == '0);
  assign a_nan  = (&ea) && (fa != '0);
  assign b_nan  = (&eb) && (fb != '0);

  // Stage 1: classify operands and normalise the product
  always_comb begin
    nan_p1_d  = a_nan || b_nan;
    snan_p1_d = (a_nan && !fa[FRAC_W-1]) || (b_nan && !fb[FRAC_W-1]);
    inf_p1_d  = a_inf || b_inf;
    zero_p1_d = a_zero || b_zero;
    sign_p1_d = in_a[W-1] ^ in_b[W-1];
    e_sum     = signed'({2'b00, ea}) + signed'({2'b00, eb}) - E_BIAS;
    if (in_prod[PROD_W-1]) begin
      sig_p1_d = in_prod[PROD_W-1 -: SIG_W];
      g_p1_d   = in_prod[PROD_W-SIG_W-1];
      st_p1_d  = |in_prod[PROD_W-SIG_W-2:0];
      e_p1_d   = e_sum + E_ONE;
    end else begin
      sig_p1_d = in_prod[PROD_W-2 -: SIG_W];
      g_p1_d   = in_prod[PROD_W-SIG_W-2];
      st_p1_d  = |in_prod[PROD_W-SIG_W-3:0];
      e_p1_d   = e_sum;
    end
  end

  always_ff @(posedge clk) begin
    if (adv1 && in_valid) begin
      nan_p1_q  <= nan_p1_d;
      snan_p1_q <= snan_p1_d;
      inf_p1_q  <= inf_p1_d;
      zero_p1_q <= zero_p1_d;
      sign_p1_q <= sign_p1_d;
      e_p1_q    <= e_p1_d;
      sig_p1_q  <= sig_p1_d;
      g_p1_q    <= g_p1_d;
      st_p1_q   <= st_p1_d;
    end
  end

  // Stage 2: round, resolve special cases by priority, pack
  always_comb begin
    {e_r, frac_r} = round_rne(e_p1_q, sig_p1_q, g_p1_q, st_p1_q);
    z_p2_d        = {sign_p1_q, e_r[EXP_W-1:0], frac_r};
    flags_p2_d    = {3'b000, g_p1_q | st_p1_q};
    if (nan_p1_q || (inf_p1_q && zero_p1_q)) begin
      z_p2_d     = QNAN[W-1:0];
      flags_p2_d = {snan_p1_q || (inf_p1_q && zero_p1_q), 3'b000};
    end else if (inf_p1_q) begin
      z_p2_d     = {sign_p1_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      flags_p2_d = 4'b0000;
    end else if (zero_p1_q) begin
      z_p2_d     = {sign_p1_q, {(W-1){1'b0}}};
      flags_p2_d = 4'b0000;
    end else if (e_r >= E_MAX) begin
      z_p2_d     = {sign_p1_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      flags_p2_d = 4'b0101;
    end else if (e_r < E_ONE) begin
      z_p2_d     = {sign_p1_q, {(W-1){1'b0}}};
      flags_p2_d = 4'b0011;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q   <= 1'b0;
      vld_p2_q   <= 1'b0;
      z_p2_q     <= '0;
      flags_p2_q <= '0;
    end else begin
      if (adv1) vld_p1_q <= in_valid;
      if (adv2) begin
        vld_p2_q <= vld_p1_q;
        if (vld_p1_q) begin
          z_p2_q     <= z_p2_d;
          flags_p2_q <= flags_p2_d;
        end
      end
    end
  end

endmodule
